// File: rtl/pipe_ctrl.sv
// pipe_ctrl - pipeline sequencing controller for the six-stage core
// (pc, if, id, ex, mem, wb).
//
// Merges per-stage stall requests into the stall vector and turns mem-stage
// exceptions into a flush plus a redirect PC. The flush lasts FLUSH_HOLD
// cycles in total. A stall watchdog raises a sticky flag after STALL_TIMEOUT
// consecutive stalled cycles.
//
// Optional feature: define PIPE_CTRL_STALL_CNT_EN to build a free-running
// 32-bit stall-cycle counter on stall_cycles_o. When it is undefined, the
// port is tied to zero.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stallreq_if/id/ex/mem  stall requests from the fetch/decode/execute/memory stages
//   excepttype_i      mem-stage exception code (0 = none, 0xe = ERET)
//   cp0_epc_i         CP0 EPC, the redirect target used for ERET
//   stall[5:0]        per-stage hold (bit0 pc .. bit5 wb)
//   flush             invalidate all pipeline registers
//   new_pc            redirect target, valid while flush is high
//   state_o           0 = RUN, 1 = FLUSH
//   stall_timeout_o   sticky watchdog flag
//   stall_cycles_o    stall-cycle count (zero unless the counter is built)

module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter int unsigned FLUSH_HOLD    = 1,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        state_o,
    output logic        stall_timeout_o,
    output logic [31:0] stall_cycles_o
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [31:0] ERET_CODE = 32'h0000_000e;
    localparam logic [3:0]  HOLD_INIT = 4'(FLUSH_HOLD - 1);
    localparam logic [15:0] TIMEOUT   = 16'(STALL_TIMEOUT);

    state_t      state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic [31:0] pc_hold_q, pc_hold_d;
    logic [15:0] run_cnt_q, run_cnt_d;
    logic        timeout_q, timeout_d;

    logic [5:0]  stall_c;
    logic        flush_c;
    logic [31:0] npc_c;

    // Next-state and ungated outputs.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        pc_hold_d = pc_hold_q;
        stall_c   = '0;
        flush_c   = 1'b0;
        npc_c     = '0;
        unique case (state_q)
            RUN: begin
                if (excepttype_i != '0) begin
                    // An exception overrides every stall request.
                    flush_c   = 1'b1;
                    npc_c     = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                    pc_hold_d = npc_c;
                    if (FLUSH_HOLD > 1) begin
                        state_d = FLUSH;
                        hold_d  = HOLD_INIT;
                    end
                end else if (stallreq_mem) begin
                    stall_c = 6'b011111;
                end else if (stallreq_ex) begin
                    stall_c = 6'b001111;
                end else if (stallreq_id || stallreq_if) begin
                    stall_c = 6'b000111;
                end
            end
            FLUSH: begin
                // Requests and new exceptions are ignored until the hold expires.
                flush_c = 1'b1;
                npc_c   = pc_hold_q;
                hold_d  = hold_q - 4'd1;
                if (hold_q == 4'd1) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Watchdog: count consecutive stalled cycles, saturating at TIMEOUT.
    // The flag sets on the same edge at which the count reaches TIMEOUT,
    // so it is visible exactly TIMEOUT cycles after the stall begins.
    always_comb begin
        if (flush_c || (stall_c == '0)) begin
            run_cnt_d = '0;
        end else if (run_cnt_q >= TIMEOUT) begin
            run_cnt_d = run_cnt_q;
        end else begin
            run_cnt_d = run_cnt_q + 16'd1;
        end
        timeout_d = timeout_q | (run_cnt_d == TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            hold_q    <= '0;
            pc_hold_q <= '0;
            run_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            pc_hold_q <= pc_hold_d;
            run_cnt_q <= run_cnt_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef PIPE_CTRL_STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Wraps naturally from all-ones to zero; flushes do not clear it.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_c != '0) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles_o = rst ? '0 : stall_cycles_q;
`else
    assign stall_cycles_o = '0;
`endif

    // All outputs are forced low for as long as reset is held.
    assign stall           = rst ? '0 : stall_c;
    assign flush           = rst ? 1'b0 : flush_c;
    assign new_pc          = rst ? '0 : npc_c;
    assign state_o         = rst ? 1'b0 : (state_q == FLUSH);
    assign stall_timeout_o = rst ? 1'b0 : timeout_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the six-stage core (pc, if, id, ex, mem, wb). It merges stall requests from the fetch, decode, execute and memory stages into the per-stage `stall` vector, and detects exceptions reported by the mem stage. On an exception it drives `flush` and `new_pc` for a configurable number of cycles. It also runs a stall watchdog and an optional stall-cycle counter. It feeds every pipeline register (pc_reg through the mem→wb register) and the pc generator.

## Interface
Parameters:
- `EXC_VECTOR`, 32'h0000_0020: handler entry address for all non-ERET exceptions.
- `FLUSH_HOLD`, 1: cycles `flush` stays asserted per exception; legal range 1..15.
- `STALL_TIMEOUT`, 1024: consecutive stalled cycles before the watchdog trips; legal range 1..65535.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stallreq_if`  in  1  instruction bus wait.
- `stallreq_id`  in  1  decode hazard (load-use).
- `stallreq_ex`  in  1  multi-cycle execute (mul/div/madd).
- `stallreq_mem`  in  1  data bus wait.
- `excepttype_i`  in  32  mem-stage exception code; 0 means no exception.
- `cp0_epc_i`  in  32  current CP0 EPC value.
- `stall`  out  6  bit0 pc … bit5 wb; 1 = hold that stage.
- `flush`  out  1  invalidate all pipeline registers.
- `new_pc`  out  32  redirect target, valid while `flush`=1.
- `state_o`  out  1  0 = RUN, 1 = FLUSH.
- `stall_timeout_o`  out  1  sticky watchdog flag.
- `stall_cycles_o`  out  32  stall-cycle count (see Configuration).

## Operation
- While `rst`=1, every output is 0: `stall`=6'b0, `flush`=0, `new_pc`=0, `state_o`=0, `stall_timeout_o`=0, `stall_cycles_o`=0.
- All internal registers clear on reset.
- RUN state, when `excepttype_i`≠0:
  - `flush`=1 and `stall`=0 in the same cycle; exceptions take priority over all stall requests.
  - `new_pc` = `cp0_epc_i` if `excepttype_i`==32'h0000_000e (ERET), otherwise `EXC_VECTOR`.
  - The target is latched into `pc_hold`.
  - If `FLUSH_HOLD`>1, the next state is FLUSH and the hold counter loads `FLUSH_HOLD`−1; otherwise the state stays RUN.
- RUN state, no exception: `stall` is chosen by priority.
  - `stallreq_mem` → 6'b011111
  - else `stallreq_ex` → 6'b001111
  - else `stallreq_id` → 6'b000111
  - else `stallreq_if` → 6'b000111
  - else 6'b000000
- FLUSH state:
  - `flush`=1, `new_pc`=`pc_hold`, `stall`=0.
  - All stall requests and `excepttype_i` are ignored.
  - The counter decrements each cycle; when it reaches 1, the next state is RUN.
- Watchdog:
  - `run_cnt` (16 bits) increments each cycle that `stall`≠0.
  - It clears on any cycle with `stall`==0 or `flush`=1, and saturates at `STALL_TIMEOUT`.
  - When `run_cnt` reaches `STALL_TIMEOUT`, `stall_timeout_o` sets on the next edge. It clears only on `rst`.
  - The flag does not alter `stall`; the stall continues.

## Timing
- `stall`, `flush` and `new_pc` in RUN are combinational from the inputs, with zero-cycle latency.
- Total flush duration is exactly `FLUSH_HOLD` cycles: one cycle in RUN plus `FLUSH_HOLD`−1 cycles in FLUSH.
- An exception arriving on the last FLUSH cycle is ignored. An exception present on the first RUN cycle after FLUSH starts a new flush.
- Exception and `stallreq_mem` in the same cycle: flush wins and `stall`=0.
- Reset mid-FLUSH: the next cycle is RUN with all outputs 0, and `pc_hold` is cleared.
- Watchdog: with the default timeout, a continuous stall starting at cycle 0 sets `stall_timeout_o` visible at cycle 1024.

## Configuration
- `PIPE_CTRL_STALL_CNT_EN` defined: `stall_cycles_o` is a 32-bit register.
  - It increments on each cycle with `stall`≠0 and wraps from 32'hFFFF_FFFF to 0.
  - It is not cleared by flush, only by `rst`.
- Macro undefined: `stall_cycles_o` is tied to 32'h0 and no counter logic is built. The port remains present.

## Test plan
- Reset: hold `rst` 3 cycles with all requests high → all outputs 0. Release → `stall`=6'b011111.
- Priority: `stallreq_id`=1 and `stallreq_ex`=1 → `stall`=6'b001111. Drop `stallreq_ex` → `stall`=6'b000111.
- Exception: `excepttype_i`=32'h8, `stallreq_mem`=1, `FLUSH_HOLD`=3 → `flush`=1 for exactly 3 cycles, `new_pc`=32'h20, `stall`=0 throughout, `state_o`=1 for cycles 2–3.
- ERET: `cp0_epc_i`=32'h0000_1234, `excepttype_i`=32'he → `new_pc`=32'h1234 for the whole flush. Changing `cp0_epc_i` mid-flush does not change `new_pc`.
- Watchdog: `STALL_TIMEOUT`=8, `stallreq_ex` held → `stall_timeout_o` rises after 8 stalled cycles and stays 1 after the request drops.
- Counter (macro on): 5 stalled cycles plus 3 idle → `stall_cycles_o`=5. Macro off → always 0.
